sort_stream_adapter_13: RTL and testbench



---
 rtl/sort_stream_adapter_13.sv | 150 +++++++++++++++
 tb/tb_sort_stream_adapter_13.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_stream_adapter_13.sv
// Stream adapter around an N-input sort/median network: fills N words, waits LATENCY cycles, drains the sorted frame.
// Optional macro SORT_CHECK_EN adds a sticky sortedness checker on sort_err.
module sort_stream_adapter_13 #(
    parameter int N       = 13,
    parameter int W       = 32,
    parameter int LATENCY = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [W-1:0]   s_data,
    output logic [N*W-1:0] par_data_o,
    input  logic [N*W-1:0] par_sort_i,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [W-1:0]   m_data,
    output logic           m_last,
    output logic [W-1:0]   median_o,
    output logic           median_valid,
    output logic           sort_err
);

    localparam int CW  = $clog2(N);
    localparam int WCW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam int MID = (N - 1) / 2;

    typedef enum logic [1:0] {FILL, WAIT, DRAIN} state_t;

    state_t         state_q;
    logic [W-1:0]   slot_q [N];
    logic [W-1:0]   snap_q [N];
    logic [W-1:0]   sortSlot [N];
    logic [CW-1:0]  wordCnt_q, wordCnt_d;
    logic [CW-1:0]  idx_q, idx_d;
    logic [WCW-1:0] waitCnt_q, waitCnt_d;
    logic           sReady_q, mValid_q, mLast_q, medianValid_q;
    logic [W-1:0]   mData_q, median_q;
    logic           captureNow;

    for (genvar k = 0; k < N; k++) begin : g_slots
        assign par_data_o[k*W +: W] = slot_q[k];
        assign sortSlot[k]          = par_sort_i[k*W +: W];
    end

    assign wordCnt_d  = wordCnt_q + 1'b1;
    assign idx_d      = idx_q + 1'b1;
    assign waitCnt_d  = waitCnt_q + 1'b1;
    assign captureNow = (state_q == WAIT) && (waitCnt_q == WCW'(LATENCY));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FILL;
            wordCnt_q     <= '0;
            idx_q         <= '0;
            waitCnt_q     <= '0;
            sReady_q      <= 1'b0;
            mValid_q      <= 1'b0;
            mLast_q       <= 1'b0;
            mData_q       <= '0;
            median_q      <= '0;
            medianValid_q <= 1'b0;
            for (int k = 0; k < N; k++) begin
                slot_q[k] <= '0;
                snap_q[k] <= '0;
            end
        end else begin
            medianValid_q <= 1'b0;
            case (state_q)
                FILL: begin
                    sReady_q <= 1'b1;
                    if (s_valid && sReady_q) begin
                        slot_q[wordCnt_q] <= s_data;
                        if (wordCnt_q == CW'(N - 1)) begin
                            wordCnt_q <= '0;
                            sReady_q  <= 1'b0;
                            state_q   <= WAIT;
                        end else begin
                            wordCnt_q <= wordCnt_d;
                        end
                    end
                end
                WAIT: begin
                    if (captureNow) begin
                        for (int k = 0; k < N; k++) snap_q[k] <= sortSlot[k];
                        median_q      <= sortSlot[MID];
                        medianValid_q <= 1'b1;
                        mValid_q      <= 1'b1;
                        mData_q       <= sortSlot[0];
                        mLast_q       <= 1'b0;
                        waitCnt_q     <= '0;
                        idx_q         <= '0;
                        state_q       <= DRAIN;
                    end else begin
                        waitCnt_q <= waitCnt_d;
                    end
                end
                DRAIN: begin
                    // Output registers only advance on a handshake, so they hold under backpressure.
                    if (mValid_q && m_ready) begin
                        if (idx_q == CW'(N - 1)) begin
                            idx_q    <= '0;
                            mValid_q <= 1'b0;
                            mLast_q  <= 1'b0;
                            sReady_q <= 1'b1;
                            state_q  <= FILL;
                        end else begin
                            idx_q   <= idx_d;
                            mData_q <= snap_q[idx_d];
                            mLast_q <= (idx_d == CW'(N - 1));
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

`ifdef SORT_CHECK_EN
    logic sortErr_q;
    logic unsorted;

    always_comb begin
        unsorted = 1'b0;
        for (int k = 0; k < N - 1; k++) begin
            if (sortSlot[k] > sortSlot[k+1]) unsorted = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sortErr_q <= 1'b0;
        end else if (captureNow && unsorted) begin
            sortErr_q <= 1'b1;
        end
    end

    assign sort_err = sortErr_q;
`else
    assign sort_err = 1'b0;
`endif

    assign s_ready      = sReady_q;
    assign m_valid      = mValid_q;
    assign m_data       = mData_q;
    assign m_last       = mLast_q;
    assign median_o     = median_q;
    assign median_valid = medianValid_q;

endmodule

// File: tb/tb_sort_stream_adapter_13.sv
// Scoreboard bench for sort_stream_adapter_13: a combinational (LATENCY=0) and a 3-stage (LATENCY=3) instance.
module tb_sort_stream_adapter_13;

    localparam int N = 13;
    localparam int W = 32;
`ifdef SORT_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, sValid, mReady, sel, swapEn, toggleEn;
    logic [W-1:0]   sData;
    logic           sReady0, mValid0, mLast0, medianValid0, sortErr0;
    logic           sReady3, mValid3, mLast3, medianValid3, sortErr3;
    logic [W-1:0]   mData0, median0, mData3, median3;
    logic [N*W-1:0] parData0, parSort0, parData3, parSort3;
    logic [N*W-1:0] pipe1, pipe2, pipe3;
    logic           sValid0, sValid3;

    logic           sReady, mValid, mLast, medianValid, sortErr;
    logic [W-1:0]   mData, median;
    logic [N*W-1:0] parData;

    int   nVec = 0;
    int   nMis = 0;
    int   popCnt = 0;
    exp_t expQ[$];
    exp_t eItem;

    sort_stream_adapter_13 #(.N(N), .W(W), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .s_valid(sValid0), .s_ready(sReady0), .s_data(sData),
        .par_data_o(parData0), .par_sort_i(parSort0), .m_valid(mValid0), .m_ready(mReady),
        .m_data(mData0), .m_last(mLast0), .median_o(median0), .median_valid(medianValid0),
        .sort_err(sortErr0)
    );

    sort_stream_adapter_13 #(.N(N), .W(W), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .s_valid(sValid3), .s_ready(sReady3), .s_data(sData),
        .par_data_o(parData3), .par_sort_i(parSort3), .m_valid(mValid3), .m_ready(mReady),
        .m_data(mData3), .m_last(mLast3), .median_o(median3), .median_valid(medianValid3),
        .sort_err(sortErr3)
    );

    // Only the selected instance sees s_valid; all observation goes through one muxed view
    assign sValid0     = sValid && !sel;
    assign sValid3     = sValid && sel;
    assign sReady      = sel ? sReady3 : sReady0;
    assign mValid      = sel ? mValid3 : mValid0;
    assign mData       = sel ? mData3 : mData0;
    assign mLast       = sel ? mLast3 : mLast0;
    assign median      = sel ? median3 : median0;
    assign medianValid = sel ? medianValid3 : medianValid0;
    assign sortErr     = sel ? sortErr3 : sortErr0;
    assign parData     = sel ? parData3 : parData0;

    function automatic logic [N*W-1:0] netModel(input logic [N*W-1:0] v, input logic sw);
        logic [W-1:0]   a[N];
        logic [W-1:0]   t;
        logic [N*W-1:0] r;
        for (int k = 0; k < N; k++) a[k] = v[k*W +: W];
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N - 1 - i; j++) begin
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
            end
        end
        if (sw) begin
            t = a[5]; a[5] = a[6]; a[6] = t;
        end
        for (int k = 0; k < N; k++) r[k*W +: W] = a[k];
        return r;
    endfunction

    always_comb parSort0 = netModel(parData0, swapEn);

    always @(posedge clk) begin
        pipe1 <= netModel(parData3, 1'b0);
        pipe2 <= pipe1;
        pipe3 <= pipe2;
    end
    assign parSort3 = pipe3;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each handshake and checks hold-stability while stalled
    logic [W-1:0] holdData;
    logic         holdLast;
    logic         holdPending = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            holdPending = 1'b0;
        end else begin
            if (holdPending && mValid) begin
                checkOutput("stall m_data hold", mData, holdData);
                checkOutput("stall m_last hold", mLast, holdLast);
            end
            holdPending = 1'b0;
            if (mValid && !mReady) begin
                holdPending = 1'b1;
                holdData    = mData;
                holdLast    = mLast;
            end
            if (mValid && mReady) begin
                if (expQ.size() == 0) begin
                    nVec++;
                    nMis++;
                    $display("[TB] FAIL unexpected word: got %0h expected none", mData);
                end else begin
                    eItem = expQ.pop_front();
                    checkOutput("m_data", mData, eItem.data);
                    checkOutput("m_last", mLast, eItem.last);
                    popCnt++;
                end
            end
        end
    end

    initial begin
        int ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (toggleEn) begin
                mReady = (ph == 0) || (ph == 3);
                ph = (ph + 1) % 4;
            end
        end
    end

    task automatic sendBeats(input logic [W-1:0] words[N], input logic [W-1:0] exp[N]);
        int t;
        popCnt = 0;
        for (int i = 0; i < N; i++) expQ.push_back('{data: exp[i], last: (i == N - 1)});
        for (int i = 0; i < N; i++) begin
            sValid = 1'b1;
            sData  = words[i];
            t = 0;
            @(negedge clk);
            while (!sReady && t < 100) begin
                @(negedge clk);
                t++;
            end
            checkOutput("s_ready during fill", sReady, 1'b1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] words[N], input logic [W-1:0] exp[N],
                                 input logic [W-1:0] expMed, input int lat, input bit junk);
        int k;
        int t;
        sendBeats(words, exp);
        sValid = junk;
        sData  = junk ? 32'hDEADBEEF : 32'h0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                checkOutput("slot 0", parData[0 +: W], words[0]);
                checkOutput("slot N-1", parData[(N-1)*W +: W], words[N-1]);
            end
        end while (!medianValid && k < 50);
        checkOutput("capture latency", k, lat + 2);
        checkOutput("median_o", median, expMed);
        @(negedge clk);
        checkOutput("median_valid single pulse", medianValid, 1'b0);
        t = 0;
        while ((expQ.size() != 0 || mValid) && t < 500) begin
            @(negedge clk);
            #1;
            t++;
        end
        sValid = 1'b0;
        checkOutput("drain finished", (t < 500), 1'b1);
        checkOutput("s_ready after drain", sReady, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues();
        checkOutput("reset m_valid", mValid, 1'b0);
        checkOutput("reset m_last", mLast, 1'b0);
        checkOutput("reset m_data", mData, 0);
        checkOutput("reset median_o", median, 0);
        checkOutput("reset median_valid", medianValid, 1'b0);
        checkOutput("reset s_ready", sReady, 1'b0);
        checkOutput("reset sort_err", sortErr, 1'b0);
        checkOutput("reset slot 0", parData[0 +: W], 0);
        checkOutput("reset slot N-1", parData[(N-1)*W +: W], 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [W-1:0] wv[N];
        logic [W-1:0] ev[N];
        logic [W-1:0] w3[N];
        logic [W-1:0] e3[N];
        int t;

        sel = 1'b0; rst = 1'b1; sValid = 1'b0; sData = '0;
        mReady = 1'b1; swapEn = 1'b0; toggleEn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetValues();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("s_ready after reset", sReady, 1'b1);
        @(posedge clk); #1;

        $display("[TB] frame: descending 13..1, no backpressure");
        for (int i = 0; i < N; i++) begin
            wv[i] = W'(N - i);
            ev[i] = W'(i + 1);
        end
        applyStimulus(wv, ev, 32'd7, 0, 1'b0);
        checkOutput("sort_err on sorted data", sortErr, 1'b0);

        $display("[TB] frame: m_ready 1,0,0,1 and junk held on s_valid");
        wv = '{800, 300, 1200, 100, 900, 600, 1300, 200, 1100, 400, 1000, 500, 700};
        ev = '{100, 200, 300, 400, 500, 600, 700, 800, 900, 1000, 1100, 1200, 1300};
        toggleEn = 1'b1;
        applyStimulus(wv, ev, 32'd700, 0, 1'b1);
        toggleEn = 1'b0;
        mReady = 1'b1;

        $display("[TB] frame: duplicates, clean restart after junk");
        w3 = '{7, 7, 7, 3, 3, 9, 9, 1, 1, 5, 5, 0, 2};
        e3 = '{0, 1, 1, 2, 3, 3, 5, 5, 7, 7, 7, 9, 9};
        applyStimulus(w3, e3, 32'd5, 0, 1'b0);

        $display("[TB] frame: LATENCY=3 instance");
        sel = 1'b1;
        wv = '{100, 5, 5, 32'hFFFFFFFF, 7, 0, 42, 5, 1000, 3, 32'hFFFFFFFE, 8, 9};
        ev = '{0, 3, 5, 5, 5, 7, 8, 9, 42, 100, 1000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        applyStimulus(wv, ev, 32'd8, 3, 1'b0);
        sel = 1'b0;

        $display("[TB] frame: network swaps slots 5 and 6");
        swapEn = 1'b1;
        wv = '{9, 2, 11, 4, 13, 6, 1, 8, 3, 10, 5, 12, 7};
        ev = '{1, 2, 3, 4, 5, 7, 6, 8, 9, 10, 11, 12, 13};
        applyStimulus(wv, ev, 32'd6, 0, 1'b0);
        checkOutput("sort_err after bad frame", sortErr, EXP_ERR);
        swapEn = 1'b0;
        applyStimulus(w3, e3, 32'd5, 0, 1'b0);
        checkOutput("sort_err sticky", sortErr, EXP_ERR);

        $display("[TB] frame: reset after 4 drained words");
        for (int i = 0; i < N; i++) begin
            wv[i] = W'(N - i);
            ev[i] = W'(i + 1);
        end
        sendBeats(wv, ev);
        sValid = 1'b0;
        t = 0;
        while (popCnt < 4 && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        checkOutput("words drained before abort", popCnt, 4);
        @(posedge clk); #1;
        rst = 1'b1;
        expQ.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkResetValues();
        @(posedge clk);
        @(negedge clk);
        checkOutput("s_ready after abort", sReady, 1'b1);
        @(posedge clk); #1;
        applyStimulus(w3, e3, 32'd5, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
